// File: rtl/fetch_stage.sv
// F stage of the P7 MIPS pipeline: owns the PC, drives the instruction-memory
// address, flags fetch-address faults and marks delay-slot instructions.
module fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_LO     = 32'h0000_3000,
   parameter logic [31:0] IM_HI     = 32'h0000_6FFC,
   parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        req,
   input  logic        d_eret,
   input  logic [31:0] epc,
   input  logic        d_br_taken,
   input  logic [31:0] d_br_target,
   input  logic        d_is_brjmp,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] f_pc,
   output logic [31:0] f_instr,
   output logic        f_bd,
   output logic [4:0]  f_exc_code
);

   logic [31:0] pc_q;
   logic        eret_q;
   logic [31:0] pc_next;
   logic        eret_next;
   logic        fault;

   // eret fetches from EPC in the same cycle, so it has no delay slot.
   assign f_pc        = d_eret ? epc : pc_q;
   assign i_inst_addr = f_pc;
   assign f_bd        = d_is_brjmp & ~d_eret;

   assign fault = (f_pc[1:0] != 2'b00) || (f_pc < IM_LO) || (f_pc > IM_HI);

   always_comb begin
      f_instr    = i_inst_rdata;
      f_exc_code = 5'd0;
      if (fault) begin
         f_instr    = 32'd0;
         f_exc_code = EXC_ADEL;
      end
   end

   // A faulting PC keeps advancing; the fault comes back later as req.
   always_comb begin
      pc_next   = pc_q + 32'd4;
      eret_next = 1'b0;
      if (req) begin
         pc_next = EXC_ENTRY;
      end else if (!en) begin
         pc_next   = pc_q;
         eret_next = eret_q;
      end else if (d_eret) begin
         pc_next   = epc + 32'd4;
         eret_next = 1'b1;
      end else if (d_br_taken) begin
         pc_next = d_br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= PC_RESET;
         eret_q <= 1'b0;
      end else begin
         pc_q   <= pc_next;
         eret_q <= eret_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirects, faults
// and reset priority, each scenario checked inline against hand-computed values.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        en;
   logic        req;
   logic        d_eret;
   logic [31:0] epc;
   logic        d_br_taken;
   logic [31:0] d_br_target;
   logic        d_is_brjmp;
   logic [31:0] i_inst_rdata;
   logic [31:0] i_inst_addr;
   logic [31:0] f_pc;
   logic [31:0] f_instr;
   logic        f_bd;
   logic [4:0]  f_exc_code;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .req          (req),
      .d_eret       (d_eret),
      .epc          (epc),
      .d_br_taken   (d_br_taken),
      .d_br_target  (d_br_target),
      .d_is_brjmp   (d_is_brjmp),
      .i_inst_rdata (i_inst_rdata),
      .i_inst_addr  (i_inst_addr),
      .f_pc         (f_pc),
      .f_instr      (f_instr),
      .f_bd         (f_bd),
      .f_exc_code   (f_exc_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model: each word is a recognisable pattern of its address.
   function automatic logic [31:0] im_word(input logic [31:0] a);
      return 32'hA5A5_0000 ^ a;
   endfunction

   assign i_inst_rdata = im_word(i_inst_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      en          = 1'b1;
      req         = 1'b0;
      d_eret      = 1'b0;
      epc         = 32'd0;
      d_br_taken  = 1'b0;
      d_br_target = 32'd0;
      d_is_brjmp  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (f_pc !== 32'h3000) begin
         errors++;
         $display("FAIL reset_pc: got %h want %h", f_pc, 32'h3000);
      end
      checks++;
      if (i_inst_addr !== 32'h3000) begin
         errors++;
         $display("FAIL reset_addr: got %h want %h", i_inst_addr, 32'h3000);
      end
      checks++;
      if (f_instr !== 32'hA5A5_3000 || f_exc_code !== 5'd0) begin
         errors++;
         $display("FAIL reset_instr: got %h/%0d want %h/0", f_instr, f_exc_code, 32'hA5A5_3000);
      end
      checks++;
      if (dut.eret_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_eret_q: got %b want 0", dut.eret_q);
      end
      d_is_brjmp = 1'b1;
      #1;
      checks++;
      if (f_bd !== 1'b1) begin
         errors++;
         $display("FAIL reset_bd: got %b want 1", f_bd);
      end
      d_is_brjmp = 1'b0;
      #1;
      $display("test_reset: pc=%h instr=%h", f_pc, f_instr);
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h3000;
      exp_pc[1] = 32'h3004;
      exp_pc[2] = 32'h3008;
      exp_pc[3] = 32'h300C;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (f_pc !== exp_pc[i] || f_instr !== im_word(exp_pc[i]) || f_exc_code !== 5'd0) begin
            errors++;
            $display("FAIL seq[%0d]: got pc=%h instr=%h exc=%0d want pc=%h instr=%h exc=0",
                     i, f_pc, f_instr, f_exc_code, exp_pc[i], im_word(exp_pc[i]));
         end
         $display("test_sequential: cycle %0d pc=%h", i, f_pc);
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (f_pc !== 32'h3008) begin
            errors++;
            $display("FAIL stall[%0d]: got %h want %h", i, f_pc, 32'h3008);
         end
         tick();
      end
      req = 1'b1;
      tick();
      clear_inputs();
      en = 1'b0;
      #1;
      checks++;
      if (f_pc !== 32'h4180) begin
         errors++;
         $display("FAIL stall_req: got %h want %h", f_pc, 32'h4180);
      end
      en = 1'b1;
      $display("test_stall: pc after req=%h", f_pc);
   endtask

   task automatic test_branch();
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      d_is_brjmp  = 1'b1;
      d_br_taken  = 1'b1;
      d_br_target = 32'h3100;
      #1;
      checks++;
      if (f_pc !== 32'h3010 || f_bd !== 1'b1) begin
         errors++;
         $display("FAIL branch_slot: got pc=%h bd=%b want pc=%h bd=1", f_pc, f_bd, 32'h3010);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h3100 || f_bd !== 1'b0) begin
         errors++;
         $display("FAIL branch_target: got pc=%h bd=%b want pc=%h bd=0", f_pc, f_bd, 32'h3100);
      end
      // A taken branch request is ignored while stalled.
      en          = 1'b0;
      d_br_taken  = 1'b1;
      d_br_target = 32'h3400;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h3100) begin
         errors++;
         $display("FAIL branch_stalled: got %h want %h", f_pc, 32'h3100);
      end
      $display("test_branch: pc=%h", f_pc);
   endtask

   task automatic test_eret();
      do_reset();
      d_eret     = 1'b1;
      epc        = 32'h3204;
      d_is_brjmp = 1'b1;
      #1;
      checks++;
      if (f_pc !== 32'h3204 || i_inst_addr !== 32'h3204 || f_bd !== 1'b0 || f_instr !== 32'hA5A5_3204) begin
         errors++;
         $display("FAIL eret_same: got pc=%h addr=%h bd=%b instr=%h want 3204/3204/0/a5a53204",
                  f_pc, i_inst_addr, f_bd, f_instr);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h3208 || dut.eret_q !== 1'b1) begin
         errors++;
         $display("FAIL eret_next: got pc=%h eret_q=%b want pc=%h eret_q=1", f_pc, dut.eret_q, 32'h3208);
      end
      tick();
      checks++;
      if (f_pc !== 32'h320C || dut.eret_q !== 1'b0) begin
         errors++;
         $display("FAIL eret_clear: got pc=%h eret_q=%b want pc=%h eret_q=0", f_pc, dut.eret_q, 32'h320C);
      end
      d_eret = 1'b1;
      epc    = 32'h3204;
      req    = 1'b1;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h4180 || dut.eret_q !== 1'b0) begin
         errors++;
         $display("FAIL eret_req: got pc=%h eret_q=%b want pc=%h eret_q=0", f_pc, dut.eret_q, 32'h4180);
      end
      d_eret      = 1'b1;
      epc         = 32'h3500;
      d_br_taken  = 1'b1;
      d_br_target = 32'h3600;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h3504) begin
         errors++;
         $display("FAIL eret_over_branch: got %h want %h", f_pc, 32'h3504);
      end
      req         = 1'b1;
      d_br_taken  = 1'b1;
      d_br_target = 32'h3600;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h4180) begin
         errors++;
         $display("FAIL req_over_branch: got %h want %h", f_pc, 32'h4180);
      end
      $display("test_eret: pc=%h", f_pc);
   endtask

   task automatic test_fault();
      logic [31:0] tgt   [5];
      logic [4:0]  code  [5];
      tgt[0] = 32'h3102;  code[0] = 5'd4;
      tgt[1] = 32'h7000;  code[1] = 5'd4;
      tgt[2] = 32'h2FFC;  code[2] = 5'd4;
      tgt[3] = 32'h6FFC;  code[3] = 5'd0;
      tgt[4] = 32'h3000;  code[4] = 5'd0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         d_br_taken  = 1'b1;
         d_br_target = tgt[i];
         tick();
         clear_inputs();
         #1;
         checks++;
         if (f_pc !== tgt[i] || f_exc_code !== code[i] ||
             f_instr !== ((code[i] != 5'd0) ? 32'd0 : im_word(tgt[i]))) begin
            errors++;
            $display("FAIL fault[%0d]: got pc=%h exc=%0d instr=%h want pc=%h exc=%0d",
                     i, f_pc, f_exc_code, f_instr, tgt[i], code[i]);
         end
         $display("test_fault: pc=%h exc=%0d", f_pc, f_exc_code);
      end
      // Faulting PC still advances, and the top of the address space wraps to 0.
      d_br_taken  = 1'b1;
      d_br_target = 32'hFFFF_FFFC;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'hFFFF_FFFC || f_exc_code !== 5'd4) begin
         errors++;
         $display("FAIL fault_top: got pc=%h exc=%0d want fffffffc/4", f_pc, f_exc_code);
      end
      tick();
      checks++;
      if (f_pc !== 32'h0 || f_exc_code !== 5'd4 || f_instr !== 32'd0) begin
         errors++;
         $display("FAIL fault_wrap: got pc=%h exc=%0d instr=%h want 0/4/0", f_pc, f_exc_code, f_instr);
      end
      $display("test_fault: wrap pc=%h", f_pc);
   endtask

   task automatic test_reset_priority();
      do_reset();
      d_eret = 1'b1;
      epc    = 32'h3300;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (dut.eret_q !== 1'b1 || f_pc !== 32'h3304) begin
         errors++;
         $display("FAIL pre_reset: got pc=%h eret_q=%b want 3304/1", f_pc, dut.eret_q);
      end
      reset       = 1'b1;
      req         = 1'b1;
      d_br_taken  = 1'b1;
      d_br_target = 32'h3600;
      en          = 1'b0;
      tick();
      reset = 1'b0;
      clear_inputs();
      #1;
      checks++;
      if (f_pc !== 32'h3000 || dut.eret_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority: got pc=%h eret_q=%b want 3000/0", f_pc, dut.eret_q);
      end
      $display("test_reset_priority: pc=%h", f_pc);
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_eret();
      test_fault();
      test_reset_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
